// File: rtl/window_gen_3x3_if.sv
// Pixel-stream and 3x3-window bundle for window_gen_3x3.
// Optional macro WINDOW_GEN_CNT_EN adds the win_count window counter.
interface window_gen_3x3_if;
  logic [7:0]  pix_in;
  logic        pix_valid;
  logic [7:0]  window_pixel_1;
  logic [7:0]  window_pixel_2;
  logic [7:0]  window_pixel_3;
  logic [7:0]  window_pixel_4;
  logic [7:0]  window_pixel_5;
  logic [7:0]  window_pixel_6;
  logic [7:0]  window_pixel_7;
  logic [7:0]  window_pixel_8;
  logic [7:0]  window_pixel_9;
  logic        window_valid;
  logic        frame_done;
`ifdef WINDOW_GEN_CNT_EN
  logic [15:0] win_count;
`endif

  // Pixel source side: drives the stream, observes the windows
  modport master (
    output pix_in, pix_valid,
    input  window_pixel_1, window_pixel_2, window_pixel_3,
    input  window_pixel_4, window_pixel_5, window_pixel_6,
    input  window_pixel_7, window_pixel_8, window_pixel_9,
`ifdef WINDOW_GEN_CNT_EN
    input  win_count,
`endif
    input  window_valid, frame_done
  );

  // Window generator side
  modport slave (
    input  pix_in, pix_valid,
    output window_pixel_1, window_pixel_2, window_pixel_3,
    output window_pixel_4, window_pixel_5, window_pixel_6,
    output window_pixel_7, window_pixel_8, window_pixel_9,
`ifdef WINDOW_GEN_CNT_EN
    output win_count,
`endif
    output window_valid, frame_done
  );
endinterface

// File: rtl/window_gen_3x3.sv
// Raster-scan 3x3 window generator with two row line buffers; interior windows only.
// Optional macro WINDOW_GEN_CNT_EN adds a saturating per-frame window counter.
module window_gen_3x3 #(
  parameter int IMG_WIDTH  = 16,
  parameter int IMG_HEIGHT = 16
) (
  input  logic             clk,
  input  logic             Reset,
  window_gen_3x3_if.slave  bus
);

  localparam int CW = $clog2(IMG_WIDTH);
  localparam int RW = $clog2(IMG_HEIGHT);

  // lb0 = previous row, lb1 = row before that; contents need no reset
  logic [7:0]      lb0_q [IMG_WIDTH];
  logic [7:0]      lb1_q [IMG_WIDTH];

  logic [CW-1:0]   col_q, col_d;
  logic [RW-1:0]   row_q, row_d;
  logic [8:0][7:0] win_q, win_d;
  logic            valid_q, valid_d;
  logic            fd_q, fd_d;
  logic [7:0]      a_s, b_s;
  logic            col_last_s, row_last_s, interior_s;

`ifdef WINDOW_GEN_CNT_EN
  logic [15:0]     cnt_q, cnt_d;
`endif

  assign a_s        = lb1_q[col_q];
  assign b_s        = lb0_q[col_q];
  assign col_last_s = (col_q == CW'(IMG_WIDTH - 1));
  assign row_last_s = (row_q == RW'(IMG_HEIGHT - 1));
  assign interior_s = (row_q >= RW'(2)) && (col_q >= CW'(2));

  // Next-state: window shift, counters and output flags for an accepted pixel
  always_comb begin
    win_d   = win_q;
    col_d   = col_q;
    row_d   = row_q;
    valid_d = 1'b0;
    fd_d    = 1'b0;
    if (bus.pix_valid) begin
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = a_s;
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = b_s;
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = bus.pix_in;
      valid_d  = interior_s;
      fd_d     = row_last_s && col_last_s;
      if (col_last_s) begin
        col_d = CW'(0);
        if (row_last_s) begin
          row_d = RW'(0);
        end else begin
          row_d = row_q + RW'(1);
        end
      end else begin
        col_d = col_q + CW'(1);
      end
    end else begin
      win_d = win_q;
    end
  end

`ifdef WINDOW_GEN_CNT_EN
  // Window counter: restarts the cycle after frame_done so the full count is visible alongside it
  always_comb begin
    cnt_d = cnt_q;
    if (fd_q) begin
      cnt_d = valid_d ? 16'd1 : 16'd0;
    end else if (valid_d && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end else begin
      cnt_d = cnt_q;
    end
  end

  // Counter register
  always_ff @(posedge clk) begin
    if (Reset) begin
      cnt_q <= 16'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bus.win_count = cnt_q;
`endif

  // Line buffers: the previous row moves down into lb1 as the new pixel lands in lb0
  always_ff @(posedge clk) begin
    if (!Reset && bus.pix_valid) begin
      lb1_q[col_q] <= b_s;
      lb0_q[col_q] <= bus.pix_in;
    end
  end

  // Counters, window and output flag registers
  always_ff @(posedge clk) begin
    if (Reset) begin
      col_q   <= CW'(0);
      row_q   <= RW'(0);
      win_q   <= '0;
      valid_q <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      col_q   <= col_d;
      row_q   <= row_d;
      win_q   <= win_d;
      valid_q <= valid_d;
      fd_q    <= fd_d;
    end
  end

  assign bus.window_pixel_1 = win_q[0];
  assign bus.window_pixel_2 = win_q[1];
  assign bus.window_pixel_3 = win_q[2];
  assign bus.window_pixel_4 = win_q[3];
  assign bus.window_pixel_5 = win_q[4];
  assign bus.window_pixel_6 = win_q[5];
  assign bus.window_pixel_7 = win_q[6];
  assign bus.window_pixel_8 = win_q[7];
  assign bus.window_pixel_9 = win_q[8];
  assign bus.window_valid   = valid_q;
  assign bus.frame_done     = fd_q;

endmodule

// File: tb/tb_window_gen_3x3.sv
// Scoreboard bench for window_gen_3x3: a 4x4 instance for the directed frame tests and a
// default 16x16 instance; expected windows are derived from each pixel's image coordinates.
module tb_window_gen_3x3;

  typedef struct packed {
    logic [8:0][7:0] win;
    logic            fd;
    logic [15:0]     cnt;
  } obs_t;

  logic clk = 1'b0;
  logic Reset;
  always #5 clk = ~clk;

  window_gen_3x3_if if4 ();
  window_gen_3x3_if if16 ();

  window_gen_3x3 #(.IMG_WIDTH(4), .IMG_HEIGHT(4)) dut4 (
    .clk(clk), .Reset(Reset), .bus(if4.slave)
  );
  window_gen_3x3 dut16 (
    .clk(clk), .Reset(Reset), .bus(if16.slave)
  );

  obs_t q4[$];
  obs_t q16[$];
  int   n_pass = 0;
  int   n_total = 0;
  int   fd4_seen = 0;
  int   win16_seen = 0;
  int   r_m[2];
  int   c_m[2];
  int   cnt_m[2];
  logic fd_prev[2];

  task automatic chk(string name, logic ok, logic [95:0] act, logic [95:0] exp);
    n_total++;
    if (ok) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic obs_t sample(int sel);
    obs_t o;
    if (sel == 0) begin
      o.win = {if4.window_pixel_9, if4.window_pixel_8, if4.window_pixel_7,
               if4.window_pixel_6, if4.window_pixel_5, if4.window_pixel_4,
               if4.window_pixel_3, if4.window_pixel_2, if4.window_pixel_1};
      o.fd  = if4.frame_done;
`ifdef WINDOW_GEN_CNT_EN
      o.cnt = if4.win_count;
`else
      o.cnt = 16'd0;
`endif
    end else begin
      o.win = {if16.window_pixel_9, if16.window_pixel_8, if16.window_pixel_7,
               if16.window_pixel_6, if16.window_pixel_5, if16.window_pixel_4,
               if16.window_pixel_3, if16.window_pixel_2, if16.window_pixel_1};
      o.fd  = if16.frame_done;
`ifdef WINDOW_GEN_CNT_EN
      o.cnt = if16.win_count;
`else
      o.cnt = 16'd0;
`endif
    end
    return o;
  endfunction

  function automatic logic vld(int sel);
    return (sel == 0) ? if4.window_valid : if16.window_valid;
  endfunction

  // Monitor: pops the scoreboard whenever a DUT presents a window
  task automatic monitor(int sel);
    obs_t o;
    obs_t e;
    o = sample(sel);
`ifdef WINDOW_GEN_CNT_EN
    if (fd_prev[sel] && !vld(sel))
      chk("cnt_clear", o.cnt == 16'd0, 96'(o.cnt), 96'd0);
`endif
    fd_prev[sel] = vld(sel) && o.fd;
    if (vld(sel)) begin
      if (sel == 0 && o.fd) fd4_seen++;
      if (sel == 1) win16_seen++;
      if ((sel == 0 ? q4.size() : q16.size()) == 0) begin
        chk("spurious_window", 1'b0, 96'(o), 96'd0);
      end else begin
        e = (sel == 0) ? q4.pop_front() : q16.pop_front();
        chk(sel == 0 ? "window4" : "window16", o == e, 96'(o), 96'(e));
      end
    end else if (o.fd) begin
      chk("frame_done_without_valid", 1'b0, 96'(o.fd), 96'd0);
    end
  endtask

  always @(negedge clk) begin
    monitor(0);
    monitor(1);
  end

  task automatic idle(int n);
    if4.pix_valid  = 1'b0;
    if16.pix_valid = 1'b0;
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one pixel at the model's current (row,col) and push its window if interior
  task automatic feed(int sel, int base);
    int   w;
    int   r;
    int   c;
    obs_t e;
    logic [7:0] v;
    w = (sel == 0) ? 4 : 16;
    r = r_m[sel];
    c = c_m[sel];
    v = 8'((base + r * w + c) & 255);
    if (r >= 2 && c >= 2) begin
      if (cnt_m[sel] < 65535) cnt_m[sel]++;
      for (int k = 0; k < 9; k++)
        e.win[k] = 8'((base + (r - 2 + k / 3) * w + (c - 2 + k % 3)) & 255);
      e.fd = (r == w - 1) && (c == w - 1);
`ifdef WINDOW_GEN_CNT_EN
      e.cnt = 16'(cnt_m[sel]);
`else
      e.cnt = 16'd0;
`endif
      if (sel == 0) q4.push_back(e);
      else q16.push_back(e);
      if (e.fd) cnt_m[sel] = 0;
    end
    if (c == w - 1) begin
      c_m[sel] = 0;
      r_m[sel] = (r == w - 1) ? 0 : r + 1;
    end else begin
      c_m[sel] = c + 1;
    end
    if (sel == 0) begin
      if4.pix_in = v;  if4.pix_valid = 1'b1;
    end else begin
      if16.pix_in = v; if16.pix_valid = 1'b1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic frame(int sel, int base, int gap);
    obs_t snap;
    obs_t cur;
    int   n;
    n = (sel == 0) ? 16 : 256;
    for (int i = 0; i < n; i++) begin
      feed(sel, base);
      if (gap > 0) begin
        snap = sample(sel);
        for (int g = 0; g < gap; g++) begin
          idle(1);
          cur = sample(sel);
          chk("gap_hold", {cur.win, vld(sel), cur.fd} == {snap.win, 2'b00},
              96'({cur.win, vld(sel), cur.fd}), 96'({snap.win, 2'b00}));
        end
      end
    end
  endtask

  task automatic check_zero(string name);
    for (int s = 0; s < 2; s++)
      chk(name, {sample(s), vld(s)} == '0, 96'({sample(s), vld(s)}), 96'd0);
  endtask

  // Reset with pix_valid held high: that pixel must be discarded
  task automatic do_reset();
    Reset = 1'b1;
    if4.pix_in = 8'd99;
    if4.pix_valid = 1'b1;
    @(posedge clk);
    #1;
    check_zero("reset_cycle");
    Reset = 1'b0;
    idle(1);
    check_zero("after_reset");
    for (int s = 0; s < 2; s++) begin
      r_m[s] = 0; c_m[s] = 0; cnt_m[s] = 0;
    end
  endtask

  task automatic drain(string name);
    idle(3);
    chk(name, q4.size() == 0 && q16.size() == 0,
        96'(q4.size() + q16.size()), 96'd0);
  endtask

  initial begin
    Reset = 1'b1;
    if4.pix_in = 8'd0;  if4.pix_valid = 1'b0;
    if16.pix_in = 8'd0; if16.pix_valid = 1'b0;
    fd_prev[0] = 1'b0;  fd_prev[1] = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_zero("reset_state");
    do_reset();

    frame(0, 0, 0);
    drain("basic_drain");

    frame(0, 0, 3);
    drain("gapped_drain");

    fd4_seen = 0;
    frame(0, 0, 0);
    frame(0, 100, 0);
    drain("b2b_drain");
    chk("b2b_frame_done_count", fd4_seen == 2, 96'(fd4_seen), 96'd2);

    for (int i = 0; i < 8; i++) feed(0, 0);
    do_reset();
    frame(0, 0, 0);
    drain("midreset_drain");

    for (int i = 0; i < 12; i++) feed(0, 0);
    do_reset();
    frame(0, 0, 0);
    drain("midreset2_drain");

    win16_seen = 0;
    frame(1, 0, 0);
    drain("frame16_drain");
    chk("frame16_window_count", win16_seen == 196, 96'(win16_seen), 96'd196);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/window_gen_3x3.md
Name: window_gen_3x3

Overview:
- Raster-scan 3x3 window generator; the producer side of the 3x3 convolution interface used by the gauss blur datapath.
- Accepts one 8-bit pixel per valid cycle and stores the two previous image rows in internal line buffers.
- Presents the nine pixels of each full interior window on window_pixel_1..9, matching input_pixel_1..9 of the filter.

Parameters:
- IMG_WIDTH, 16, pixels per row; legal range 3..4096.
- IMG_HEIGHT, 16, rows per frame; legal range 3..4096.

Ports:
- clk  input  1  system clock, rising edge.
- Reset  input  1  synchronous, active-high reset.
- pix_in  input  8  incoming pixel, raster order: row-major, left to right.
- pix_valid  input  1  pix_in is accepted on this rising edge; no backpressure.
- window_pixel_1..window_pixel_9  output  8 each  window; 1 = top-left, 3 = top-right, 5 = centre, 7 = bottom-left, 9 = bottom-right.
- window_valid  output  1  window_pixel_* hold a new complete window this cycle.
- frame_done  output  1  one-cycle pulse marking the last window of a frame.

Behaviour:
- Clock and reset: one clock. Reset is synchronous and active-high and is sampled only on the rising edge of clk.
- Reset values:
  - window_pixel_1..9 = 0; window_valid = 0; frame_done = 0.
  - Column counter col = 0; row counter row = 0.
  - Line-buffer contents are don't-care after reset and are never observable.
- Line buffers:
  - lb0 holds row r-1 and lb1 holds row r-2; each has IMG_WIDTH entries of 8 bits, indexed by col.
- On an accepted pixel (pix_valid=1, Reset=0):
  - Read a = lb1[col] and b = lb0[col].
  - Write lb1[col] <= b and lb0[col] <= pix_in.
  - Shift the 3x3 window left by one column: pixel_1<=pixel_2, pixel_2<=pixel_3, pixel_4<=pixel_5, pixel_5<=pixel_6, pixel_7<=pixel_8, pixel_8<=pixel_9.
  - Load the new right column: pixel_3<=a, pixel_6<=b, pixel_9<=pix_in.
- Counters:
  - col increments on each accepted pixel.
  - At col = IMG_WIDTH-1, col wraps to 0 and row increments.
  - At row = IMG_HEIGHT-1 with col = IMG_WIDTH-1, both wrap to 0 and the next frame starts immediately.
- Output timing:
  - window_valid is registered: it is 1 in the cycle after an accept where row>=2 and col>=2 (pre-increment values), and 0 otherwise.
  - Latency from input to output is 1 cycle.
  - Exactly (IMG_WIDTH-2)*(IMG_HEIGHT-2) windows are produced per frame. Border windows are not produced (no padding).
- pix_valid=0 cycles:
  - No state change. window_pixel_* hold their values; window_valid=0 and frame_done=0.
- frame_done:
  - 1 in the same cycle as window_valid for the accept at row = IMG_HEIGHT-1, col = IMG_WIDTH-1.
- Window registers after a row wrap:
  - They still contain end-of-previous-row columns. This is harmless because valid is suppressed until col>=2.
- Mid-frame Reset:
  - Aborts the frame. Counters return to 0 and outputs are cleared.
  - A pix_valid in the same cycle as Reset is ignored.
  - The next accepted pixel is row 0, col 0.
- Widths and storage:
  - Counters use $clog2 widths of IMG_WIDTH and IMG_HEIGHT.
  - The line buffers are plain register arrays with no read latency.

Optional Feature:
- Macro WINDOW_GEN_CNT_EN.
- Defined:
  - Adds output port win_count, 16 bits, reset 0.
  - Increments in the same cycle that window_valid is asserted, saturating at 16'hFFFF.
  - Cleared to 0 in the cycle after frame_done is 1, so it shows the full frame count while frame_done is 1.
- Undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- Basic frame: IMG_WIDTH=4, IMG_HEIGHT=4; feed pixels 0..15 back-to-back after Reset.
  - The first window_valid follows the acceptance of pixel 10, with window = 0,1,2,4,5,6,8,9,10.
  - Exactly 4 valid windows are produced.
  - The last window is 5,6,7,9,10,11,13,14,15, with frame_done=1 in that same cycle only.
- Gapped input: same frame, with pix_valid deasserted for 3 cycles after every pixel.
  - Identical window sequence to the basic frame.
  - window_valid is never asserted during gap cycles, and window_pixel_* stay stable across the gaps.
- Back-to-back frames: two 4x4 frames, pixels 0..15 then 100..115 with no gap.
  - The second frame's first window is 100,101,102,104,105,106,108,109,110.
  - frame_done pulses exactly twice.
- Mid-frame reset: assert Reset after pixel 7 of a 4x4 frame, then send a fresh frame 0..15.
  - All outputs are 0 during and after the reset cycle.
  - The window sequence exactly matches the basic frame; there is no stale window_valid.
- Default size: IMG_WIDTH=16, IMG_HEIGHT=16, with pixel value = (row*16+col) mod 256.
  - 196 windows are produced.
  - Every window satisfies pixel_k = centre + offset: pixel_1 = c-17, pixel_5 = c, pixel_9 = c+17.
- With WINDOW_GEN_CNT_EN, 4x4 frame:
  - win_count reads 1,2,3,4 on successive window_valid cycles and 4 alongside frame_done.
  - win_count is 0 on the following cycle.
